// File: rtl/opl3_io_frontend.sv
// opl3_io_frontend
//   CPU-side I/O front end of an OPL3 at ports 0x388-0x38B. Latches the
//   register index, forwards every CPU write to the register-write queue,
//   emulates timers 1/2 and returns the status byte used for OPL detection.
//
//   Ports
//     clk, reset_n      clock, asynchronous active-low reset
//     io_address[1:0]   0=index bank0, 1=data bank0, 2=index bank1, 3=data bank1
//     io_writedata[7:0] CPU write data
//     io_write/io_read  one-cycle strobes
//     io_readdata[7:0]  registered read data (holds between reads)
//     q_addr/q_din/q_wr forwarded write to the OPL3 write queue
//     irq               timer interrupt (level)
//
//   Parameter CLK_FREQ sets the 80 us tick divider (CLK_FREQ/12500).
//   Optional macro OPL3_IRQ_EN drives irq from the timer flags; when it is
//   undefined irq is tied low and the flags are only visible by polling.
module opl3_io_frontend #(
  parameter int CLK_FREQ = 30000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] io_address,
  input  logic [7:0] io_writedata,
  input  logic       io_write,
  input  logic       io_read,
  output logic [7:0] io_readdata,
  output logic [1:0] q_addr,
  output logic [7:0] q_din,
  output logic       q_wr,
  output logic       irq
);
  localparam int TICK_DIV = CLK_FREQ / 12500;
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  // Timer arrays: index 0 = T1 (80 us), index 1 = T2 (320 us)
  logic [8:0]      r_idx;
  logic [1:0][7:0] r_pre, r_cnt;
  logic [1:0]      r_mask, r_start, r_flag;
  logic [DIV_W-1:0] r_div;
  logic [1:0]      r_psc;
  logic [7:0]      r_rd;
  logic [1:0]      r_qaddr;
  logic [7:0]      r_qdin;
  logic            r_qwr;

  logic       w_tick80, w_dwr, w_reg, w_wr_ctl, w_clr, w_set;
  logic [1:0] w_tick, w_wr_pre, w_load, w_ovf;
  logic [7:0] w_status;

  assign w_tick80 = (r_div == DIV_LAST);
  assign w_tick   = {w_tick80 & (r_psc == 2'd3), w_tick80};

  // Data writes only decode registers of bank 0
  assign w_dwr    = io_write & io_address[0];
  assign w_reg    = w_dwr & ~r_idx[8];
  assign w_wr_ctl = w_reg & (r_idx[7:0] == 8'h04);
  assign w_clr    = w_wr_ctl & io_writedata[7];
  assign w_set    = w_wr_ctl & ~io_writedata[7];

  always_comb begin
    w_wr_pre = '0;
    w_load   = '0;
    w_ovf    = '0;
    for (int t = 0; t < 2; t++) begin
      w_wr_pre[t] = w_reg & (r_idx[7:0] == 8'(2 + t));
      // Load on a 0->1 start edge; a coincident tick is dropped
      w_load[t]   = w_set & io_writedata[t] & ~r_start[t];
      w_ovf[t]    = r_start[t] & w_tick[t] & ~w_load[t] & (r_cnt[t] == 8'hFF);
    end
  end

  assign w_status = {r_flag[0] | r_flag[1], r_flag[0], r_flag[1], 5'b0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
      r_psc <= '0;
    end else if (w_tick80) begin
      r_div <= '0;
      r_psc <= r_psc + 2'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx   <= '0;
      r_pre   <= '0;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_start <= '0;
      r_flag  <= '0;
    end else begin
      if (io_write && !io_address[0])
        r_idx <= {io_address[1], io_writedata};
      for (int t = 0; t < 2; t++) begin
        if (w_wr_pre[t])
          r_pre[t] <= io_writedata;
        if (w_set) begin
          r_start[t] <= io_writedata[t];
          r_mask[t]  <= io_writedata[6-t];
        end
        if (w_load[t])
          r_cnt[t] <= r_pre[t];
        else if (r_start[t] && w_tick[t])
          r_cnt[t] <= w_ovf[t] ? r_pre[t] : r_cnt[t] + 8'd1;
        // Clear beats a same-cycle overflow; mask only gates new sets
        if (w_clr)
          r_flag[t] <= 1'b0;
        else if (w_ovf[t] && !r_mask[t])
          r_flag[t] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd    <= '0;
      r_qaddr <= '0;
      r_qdin  <= '0;
      r_qwr   <= 1'b0;
    end else begin
      r_qwr <= io_write;
      if (io_write) begin
        r_qaddr <= io_address;
        r_qdin  <= io_writedata;
      end
      // Status uses flag state from before any same-cycle write
      if (io_read)
        r_rd <= io_address[0] ? 8'hFF : w_status;
    end
  end

`ifdef OPL3_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_irq <= 1'b0;
    else          r_irq <= r_flag[0] | r_flag[1];
  end
  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  assign io_readdata = r_rd;
  assign q_addr      = r_qaddr;
  assign q_din       = r_qdin;
  assign q_wr        = r_qwr;

  logic w_unused;
  assign w_unused = ^r_idx[7:0] & 1'b0;
endmodule
